// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, data width and receiver state encoding.
package uart_pkg;

  localparam int unsigned BAUD_CNT_19200 = 2604;
  localparam int unsigned DATA_BITS      = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value selectable.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pc_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a sticky rdy flag.
// Define UART_RX_FRAME_ERR_EN to add frm_err and reject frames with a 0 stop bit.
module pc_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT = BAUD_CNT_19200,
  parameter int unsigned HALF_CNT = BAUD_CNT / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                 frm_err
`endif
);

  localparam logic [11:0] HALF_LD = 12'(HALF_CNT);
  localparam logic [11:0] BAUD_LD = 12'(BAUD_CNT - 1);

  logic                 rx_s;
  logic                 strobe;
  rx_state_t            state_q, state_d;
  logic [11:0]          baud_q,  baud_d;
  logic [3:0]           bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 rdy_q,   rdy_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic                 ferr_q,  ferr_d;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_rx_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  assign strobe = (state_q != IDLE) && (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d  = ferr_q;
`endif

    // Clears are applied first so a same-cycle set below takes priority.
    if (clr_rdy) begin
      rdy_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_d = 1'b0;
`endif
    end

    if (state_q != IDLE) begin
      baud_d = strobe ? BAUD_LD : baud_q - 12'd1;
      bit_d  = strobe ? bit_q + 4'd1 : bit_q;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          baud_d  = HALF_LD;
          bit_d   = '0;
          rdy_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (strobe) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (strobe) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS)) state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            ferr_d = 1'b0;
          end else begin
            ferr_d = 1'b1;
          end
`else
          data_d = shift_q;
          rdy_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign frm_err = ferr_q;
`endif

endmodule

// File: tb/tb_pc_uart_rx.sv
// Randomized self-checking bench for pc_uart_rx: a scaled-baud instance for frame traffic
// and a full-rate (2604 cycles/bit) instance for glitch rejection and absolute latency.
module tb_pc_uart_rx;
  import uart_pkg::*;

  localparam int unsigned B   = 32;
  localparam int unsigned H   = B / 2;
  localparam int unsigned BF  = BAUD_CNT_19200;
  localparam int unsigned HF  = BF / 2;
`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FERR = 1'b1;
`else
  localparam bit FERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, rst_n_f;
  logic       rx, rx_f;
  logic       clr, clr_f;
  logic [7:0] data, data_f;
  logic       rdy, rdy_f;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr, ferr_f;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  // Spec-level expectation for the scaled instance.
  logic [7:0]  exp_data = 8'h00;
  logic        exp_rdy  = 1'b0;
  logic        exp_ferr = 1'b0;

  int unsigned fall_cyc, rise_cyc, rise_cnt = 0;
  int unsigned fall_cyc_f, rise_cyc_f, rise_cnt_f = 0;
  logic        rdy_prev = 1'b0, rdy_prev_f = 1'b0;

  always #5 clk = ~clk;

  pc_uart_rx #(.BAUD_CNT(B)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .clr_rdy(clr), .rx_data(data), .rdy(rdy)
`ifdef UART_RX_FRAME_ERR_EN
    , .frm_err(ferr)
`endif
  );

  pc_uart_rx #(.BAUD_CNT(BF)) dut_full (
    .clk(clk), .rst_n(rst_n_f), .rx(rx_f), .clr_rdy(clr_f), .rx_data(data_f), .rdy(rdy_f)
`ifdef UART_RX_FRAME_ERR_EN
    , .frm_err(ferr_f)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rdy && !rdy_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    rdy_prev = rdy;
    if (rdy_f && !rdy_prev_f) begin
      rise_cnt_f++;
      rise_cyc_f = cyc;
    end
    rdy_prev_f = rdy_f;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"}, data, exp_data);
    check({tag, "_rdy"}, rdy, exp_rdy);
`ifdef UART_RX_FRAME_ERR_EN
    check({tag, "_ferr"}, ferr, exp_ferr);
`endif
  endtask

  // A received frame: bad stop (when checked) only flags an error, otherwise data lands.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (FERR && !stop) begin
      exp_ferr = 1'b1;
    end else begin
      exp_data = b;
      exp_rdy  = 1'b1;
      exp_ferr = 1'b0;
    end
  endtask

  task automatic model_clr();
    exp_rdy  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clr();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit abort,
                            input bit clr_at_start);
    rx       = 1'b0;
    fall_cyc = cyc;
    if (clr_at_start) begin
      clr = 1'b1;
      model_clr();
    end
    exp_rdy = 1'b0;
    @(negedge clk);
    if (clr_at_start) clr = 1'b0;
    wait_cyc(B - 1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 3) begin
        wait_cyc(H);
        check("hold_data", data, exp_data);
        check("start_clears_rdy", rdy, 1'b0);
        if (abort) begin
          rst_n = 1'b0;
          #1;
          check("rst_mid_data", data, 8'h00);
          check("rst_mid_rdy", rdy, 1'b0);
          exp_data = 8'h00;
          model_clr();
          rx = 1'b1;
          return;
        end
        wait_cyc(B - H);
      end else begin
        wait_cyc(B);
      end
    end
    rx = stop;
    wait_cyc(B);
    rx = 1'b1;
    model_frame(b, stop);
  endtask

  task automatic run_full();
    logic [7:0]  b = 8'hA5;
    int unsigned lat;
    rx_f = 1'b0;
    wait_cyc(500);
    rx_f = 1'b1;
    wait_cyc(1400);
    check("glitch_no_rdy", rise_cnt_f, 0);
    check("glitch_rdy_low", rdy_f, 1'b0);
    rx_f       = 1'b0;
    fall_cyc_f = cyc;
    wait_cyc(BF);
    for (int i = 0; i < 8; i++) begin
      rx_f = b[i];
      wait_cyc(BF);
    end
    rx_f = 1'b1;
    wait_cyc(BF);
    lat = rise_cyc_f - fall_cyc_f;
    check("full_data", data_f, 8'hA5);
    check("full_rdy", rdy_f, 1'b1);
    check("full_rises", rise_cnt_f, 1);
    check($sformatf("full_latency_%0d", lat),
          (lat >= HF + 9 * BF) && (lat <= HF + 9 * BF + 4), 1'b1);
`ifdef UART_RX_FRAME_ERR_EN
    check("full_ferr", ferr_f, 1'b0);
`endif
  endtask

  task automatic run_small();
    int unsigned lat, r0;
    logic [7:0]  b;
    logic        stop;

    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    lat = rise_cyc - fall_cyc;
    check_state("single");
    check($sformatf("latency_%0d", lat), (lat >= H + 9 * B) && (lat <= H + 9 * B + 4), 1'b1);

    r0 = rise_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    check_state("b2b_first");
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    check_state("b2b_second");
    check("b2b_rises", rise_cnt - r0, 2);
    pulse_clr();
    check_state("b2b_clr");

    // clr held across the set edge: set wins for that cycle, then clr drops it.
    r0  = rise_cnt;
    clr = 1'b1;
    model_clr();
    send_frame(8'h96, 1'b1, 1'b0, 1'b0);
    model_clr();
    check("hs_set_wins", rise_cnt - r0, 1);
    check_state("hs_after");
    clr = 1'b0;
    wait_cyc(2);

    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    check_state("ovr_first");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check_state("ovr_second");

    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = FERR ? ($urandom_range(0, 3) != 0) : 1'b1;
      send_frame(b, stop, 1'b0, 1'b0);
      check_state($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_state($sformatf("rnd%0d_clr", n));
      end
      if (!stop) wait_cyc(B);
      else       wait_cyc($urandom_range(0, 3));
    end

`ifdef UART_RX_FRAME_ERR_EN
    send_frame(8'h77, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check_state("ferr_bad");
    check("ferr_hold_prev", data, 8'h77);
    wait_cyc(B);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    check_state("ferr_good");
`endif

    send_frame(8'hE7, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(B);
    check_state("rst_after");
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check_state("rst_next");
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_n_f = 1'b0;
    rx      = 1'b1;
    rx_f    = 1'b1;
    clr     = 1'b0;
    clr_f   = 1'b0;
    wait_cyc(3);
    check_state("reset");
    check("reset_full_data", data_f, 8'h00);
    check("reset_full_rdy", rdy_f, 1'b0);
    rst_n   = 1'b1;
    rst_n_f = 1'b1;
    wait_cyc(3);
    fork
      run_full();
      run_small();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_uart_rx.md
Name: pc_uart_rx

Overview:
- 8N1 UART receiver: the downstream partner of the PC-side transmitter; consumes its serial line at the same bit period.
- Rx input runs on clk through a 2-flop synchronizer, with mid-bit sampling.
- Presents a received byte with a sticky rdy flag; the consumer clears it with clr_rdy.

Parameters:
- BAUD_CNT, 2604, clk cycles per bit (50 MHz / 19200 baud).
- HALF_CNT, BAUD_CNT/2 (1302), delay from start-bit falling edge to the start-bit sample point.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy.
- rx_data  output  8  last fully received byte.
- rdy  output  1  sticky byte-valid flag.

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: rx_data=8'h00, rdy=0, both synchronizer flops=1, state=IDLE, counters=0.
- Synchronizer: two flops, preset to 1. All logic uses the second-flop output (rx_s) only.
- Baud counter: 12-bit down-counter.
  - Loaded with HALF_CNT on start detect.
  - Loaded with BAUD_CNT-1 after each sample.
  - A sample strobe fires when the count reaches 0.
- Bit counter: 4-bit, counts samples 0..9 (start, d0..d7, stop).
- FSM states:
  - IDLE: on rx_s==0, load HALF_CNT, clear the bit counter, go to START.
  - START: at the strobe, sample rx_s.
    - If 1: false start (glitch shorter than half a bit). Return to IDLE; no other effect.
    - If 0: go to DATA.
  - DATA: at each strobe, shift rx_s into bit 7 of an 8-bit shift register, right-shifting (LSB first). After the 8th data sample, go to STOP.
  - STOP: at the strobe, copy the shift register to rx_data and set rdy. Return to IDLE.
- rx_data changes only at the STOP strobe. It is stable throughout the next reception.
- rdy behaviour:
  - rdy is set the cycle after the stop sample.
  - rdy is cleared by clr_rdy or by a start detect (IDLE→START).
  - If set and clear occur in the same cycle, set wins.
- Latency: rdy rises 2 + HALF_CNT + 9*BAUD_CNT cycles after rx falls, ±2 cycles.
- Overrun: if a new byte completes while rdy=1, rx_data is overwritten and rdy stays 1. There is no overrun flag.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge immediately after the stop bit is caught.
- Stop bit value is ignored, except under the optional feature.
- Reset mid-frame: returns immediately to reset values. A partial byte is discarded.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- When defined:
  - Adds output port frm_err (1 bit, reset 0).
  - If the stop sample is 0, rx_data is not updated, rdy is not set, and frm_err is set.
  - frm_err is cleared by clr_rdy or by the next good frame.
- When undefined:
  - The port is absent.
  - Every frame that passes start validation updates rx_data and sets rdy, regardless of the stop bit.

Decomposition:
- Package uart_pkg holds:
  - BAUD_CNT_19200=2604, shared with the transmitter.
  - DATA_BITS=8.
  - typedef enum rx_state_t {IDLE, START, DATA, STOP}.
- Sub-module uart_sync2: parameterizable-reset-value 2-flop synchronizer, reused for other asynchronous inputs.

Test Plan:
- Single byte: drive frame 0xA5 at 2604 cycles per bit → rdy rises at ~24740 cycles after the falling edge, rx_data=8'hA5.
- Back-to-back: frames 0x00 then 0xFF with no idle gap, clr_rdy pulsed after each → rx_data=0x00 then 0xFF, rdy asserted twice.
- Glitch rejection: rx low for 500 cycles, then high → no rdy; FSM back in IDLE ~1304 cycles after the edge.
- Handshake: clr_rdy asserted in the same cycle rdy sets → rdy=1. clr_rdy one cycle later → rdy=0. Second byte with no clr → rx_data overwritten, rdy=1.
- Reset mid-frame: assert rst_n low during d3 of 0x3C → rdy=0 and rx_data=0x00 immediately. Next frame 0x81 received correctly.
- Frame error (UART_RX_FRAME_ERR_EN): send 0x55 with stop bit 0 → frm_err=1, rdy=0, rx_data holds the previous value. Next good 0x12 → frm_err=0, rdy=1.
